// File: rtl/mvm_rf_loader.sv
// ---------------------------------------------------------------------------
// mvm_rf_loader
//
// Takes one command (RF word address, first target RF, number of weight words)
// and turns the following weight words into AXI-stream beats for the rtl_mvm
// rx port. Each beat writes one word into one register file. Every beat of a
// command writes the same RF word address. The target RF advances by one per
// beat and wraps modulo 64.
//
// Ports
//   clk, rst                     single clock, asynchronous active-high reset
//   cmd_valid / cmd_ready        command handshake
//   cmd_rf_addr                  RF word address used by every beat
//   cmd_first_rf                 index of the first target RF
//   cmd_count                    number of weight words (0..64)
//   in_valid / in_data / in_ready   weight word stream
//   axis_tx_*                    registered AXI-stream output towards rtl_mvm
//   busy                         high whenever the FSM is not IDLE
//   done                         one-cycle pulse per completed command
// ---------------------------------------------------------------------------
module mvm_rf_loader #(
    parameter int DATAW   = 512,
    parameter int USERW   = 75,
    parameter int DPES    = 64,
    parameter int RFADDRW = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [RFADDRW-1:0] cmd_rf_addr,
    input  logic [5:0]         cmd_first_rf,
    input  logic [6:0]         cmd_count,
    input  logic               in_valid,
    input  logic [DATAW-1:0]   in_data,
    output logic               in_ready,
    output logic               axis_tx_tvalid,
    output logic [DATAW-1:0]   axis_tx_tdata,
    output logic [USERW-1:0]   axis_tx_tuser,
    output logic               axis_tx_tlast,
    input  logic               axis_tx_tready,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // tuser layout: {one-hot RF select, 2'b11 RF write op, RF word address}
    function automatic logic [USERW-1:0] build_tuser(
        input logic [RFADDRW-1:0] addr,
        input logic [5:0]         idx
    );
        logic [USERW-1:0] u;
        logic [DPES-1:0]  sel;
        sel = {{(DPES-1){1'b0}}, 1'b1} << idx;
        u = {USERW{1'b0}};
        u[RFADDRW-1:0]       = addr;
        u[RFADDRW +: 2]      = 2'b11;
        u[RFADDRW + 2 +: DPES] = sel;
        return u;
    endfunction

    state_t             state_q, state_d;
    logic [RFADDRW-1:0] addr_q, addr_d;
    logic [5:0]         rf_idx_q, rf_idx_d;
    logic [6:0]         remaining_q, remaining_d;
    logic               tvalid_q, tvalid_d;
    logic [DATAW-1:0]   tdata_q, tdata_d;
    logic [USERW-1:0]   tuser_q, tuser_d;
    logic               tlast_q, tlast_d;
    logic               done_q, done_d;

    logic               in_ready_s;
    logic               load_s;
    logic               out_empty_s;

    // Output register can take a new beat when it is empty or draining this cycle
    assign in_ready_s  = (state_q == ST_STREAM) && (!tvalid_q || axis_tx_tready);
    assign load_s      = in_valid && in_ready_s;
    assign out_empty_s = !tvalid_q || axis_tx_tready;

    // Next-state and command bookkeeping
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rf_idx_d    = rf_idx_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d      = cmd_rf_addr;
                    rf_idx_d    = cmd_first_rf;
                    remaining_d = cmd_count;
                    if (cmd_count == 7'd0) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (load_s) begin
                    // 6-bit index wraps 63 -> 0 by itself
                    rf_idx_d    = rf_idx_q + 6'd1;
                    remaining_d = remaining_q - 7'd1;
                    if (remaining_q == 7'd1) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_FINISH: begin
                // done only once the last beat has left the output register
                if (out_empty_s) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FINISH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output beat register: load, drain, or hold while stalled
    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tuser_d  = tuser_q;
        tlast_d  = tlast_q;
        if (load_s) begin
            tvalid_d = 1'b1;
            tdata_d  = in_data;
            tuser_d  = build_tuser(addr_q, rf_idx_q);
            tlast_d  = 1'b1;
        end else if (tvalid_q && axis_tx_tready) begin
            tvalid_d = 1'b0;
        end else begin
            tvalid_d = tvalid_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= {RFADDRW{1'b0}};
            rf_idx_q    <= 6'd0;
            remaining_q <= 7'd0;
            tvalid_q    <= 1'b0;
            tdata_q     <= {DATAW{1'b0}};
            tuser_q     <= {USERW{1'b0}};
            tlast_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rf_idx_q    <= rf_idx_d;
            remaining_q <= remaining_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            tuser_q     <= tuser_d;
            tlast_q     <= tlast_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready      = (state_q == ST_IDLE);
    assign in_ready       = in_ready_s;
    assign busy           = (state_q != ST_IDLE);
    assign done           = done_q;
    assign axis_tx_tvalid = tvalid_q;
    assign axis_tx_tdata  = tdata_q;
    assign axis_tx_tuser  = tuser_q;
    assign axis_tx_tlast  = tlast_q;

endmodule

// File: doc/mvm_rf_loader.md
MVM_RF_LOADER -- requirements
Module: mvm_rf_loader

Interface
REQ-001 SHALL have parameter DATAW, default 512, data beat width.
REQ-002 SHALL have parameter USERW, default 75, tuser width.
REQ-003 SHALL have parameter DPES, default 64, register files (one-hot select width).
REQ-004 SHALL have parameter RFADDRW, default 9, RF word address width.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports cmd_valid input 1, cmd_ready output 1: command handshake.
REQ-008 SHALL have port cmd_rf_addr  input  RFADDRW  RF word address written by every beat of the command.
REQ-009 SHALL have port cmd_first_rf  input  6  index of first target RF.
REQ-010 SHALL have port cmd_count  input  7  number of weight words, 0..64.
REQ-011 SHALL have ports in_valid input 1, in_data input DATAW, in_ready output 1: weight word stream.
REQ-012 SHALL have ports axis_tx_tvalid output 1, axis_tx_tdata output DATAW, axis_tx_tuser output USERW, axis_tx_tlast output 1, axis_tx_tready input 1: AXI-stream towards rtl_mvm rx.
REQ-013 SHALL have ports busy output 1 (state not IDLE) and done output 1 (one-cycle pulse per completed command).

Function
REQ-014 SHALL implement FSM states IDLE, STREAM, FINISH.
REQ-015 IDLE: cmd_ready=1; on cmd_valid latch addr, first_rf, count; count!=0 -> STREAM, count==0 -> FINISH.
REQ-016 STREAM: cmd_ready=0; in_ready = !axis_tx_tvalid || axis_tx_tready.
REQ-017 Each in_valid&&in_ready beat SHALL load the output register on the same edge; beat visible on axis_tx next cycle (1-cycle latency, one beat per cycle sustained under tready=1).
REQ-018 Beat tuser SHALL be: [8:0]=latched rf_addr, [10:9]=2'b11 (RF write op), [74:11]=one-hot with only bit (11+rf_idx) set, tlast=1 on every beat.
REQ-019 rf_idx SHALL start at cmd_first_rf and increment by 1 per accepted beat, modulo 64 (63 -> 0 wrap).
REQ-020 Remaining count SHALL decrement per accepted beat; on accepting the last beat go to FINISH.
REQ-021 FINISH: wait until output register empty (axis_tx_tvalid=0 or handshake this cycle), pulse done for one cycle, return to IDLE.
REQ-022 While axis_tx_tvalid=1 and tready=0, tdata/tuser/tlast SHALL hold stable and in_ready=0.
REQ-023 axis_tx_tvalid SHALL clear after handshake when no new beat is loaded the same cycle.
REQ-024 Input beats SHALL never be accepted in IDLE or FINISH (in_ready=0).
REQ-025 A cmd_valid arriving while busy SHALL be held off (cmd_ready=0), never dropped or merged.

Reset
REQ-026 rst SHALL asynchronously force state IDLE, axis_tx_tvalid=0, axis_tx_tdata=0, axis_tx_tuser=0, axis_tx_tlast=0, done=0, busy=0, in_ready=0, cmd_ready=1 (after release), counters 0.
REQ-027 rst asserted mid-command SHALL abandon the command and any held beat; no done pulse; first command after release behaves as from power-up.

Verification
REQ-028 cmd(addr=1, first_rf=0, count=64), 64 words, tready=1 -> 64 consecutive beats, beat k tuser = {onehot bit 11+k, 2'b11, 9'h1}, tlast=1, done pulses once after beat 64.
REQ-029 cmd(first_rf=62, count=4) -> RF select bits 73, 74, 11, 12 in order (wrap).
REQ-030 tready toggled 0/1 every 2 cycles during count=8 -> all 8 words delivered once, in order, data stable while stalled, no beat lost or duplicated.
REQ-031 cmd count=0 -> no tx beats, done pulses within 2 cycles, in_ready stays 0.
REQ-032 rst asserted after 10 of 20 beats -> tvalid=0 immediately, no done; new cmd count=2 afterward -> exactly 2 beats starting at its first_rf.
REQ-033 second cmd_valid held during active command -> cmd_ready=0 until done; second command then executes fully.
